// File: rtl/sprite_motion.sv
// Per-frame sprite position generator: steps the sprite by a fixed velocity once per
// enabled frame, bounces it off the screen edges and commits both coordinates together.
module sprite_motion #(
    parameter int CORDW      = 16,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int SPR_WIDTH  = 32,
    parameter int SPR_HEIGHT = 20,
    parameter int SPR_SCALE  = 0,
    parameter int SPEED_X    = 2,
    parameter int SPEED_Y    = 1,
    parameter int FRAME_DIV  = 1,
    parameter int START_X    = 0,
    parameter int START_Y    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    pause,
    output logic signed [CORDW-1:0] sprx,
    output logic signed [CORDW-1:0] spry,
    output logic                    dir_x,
    output logic                    dir_y,
    output logic                    bounce_x,
    output logic                    bounce_y,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, COMMIT} state_t;

    localparam int DIVW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(FRAME_DIV - 1);

    // Wide signed constants keep the limit comparisons signed end to end.
    localparam logic signed [CORDW:0] LX   = (CORDW+1)'(H_RES - (SPR_WIDTH << SPR_SCALE));
    localparam logic signed [CORDW:0] LY   = (CORDW+1)'(V_RES - (SPR_HEIGHT << SPR_SCALE));
    localparam logic signed [CORDW:0] SPX  = (CORDW+1)'(SPEED_X);
    localparam logic signed [CORDW:0] SPY  = (CORDW+1)'(SPEED_Y);
    localparam logic signed [CORDW:0] ZERO = '0;

    state_t                  state;
    logic [DIVW-1:0]         div;

    logic signed [CORDW-1:0] nx_q, ny_q;
    logic                    ndx_q, ndy_q, bx_q, by_q;

    logic signed [CORDW:0]   x_wide, y_wide, x_sum, y_sum;
    logic signed [CORDW-1:0] nx_c, ny_c;
    logic                    ndx_c, ndy_c, bx_c, by_c;

    assign x_wide = {sprx[CORDW-1], sprx};
    assign y_wide = {spry[CORDW-1], spry};

    always_comb begin
        x_sum = dir_x ? (x_wide + SPX) : (x_wide - SPX);
        nx_c  = x_sum[CORDW-1:0];
        ndx_c = dir_x;
        bx_c  = 1'b0;
        if (dir_x && (x_sum >= LX)) begin
            nx_c  = LX[CORDW-1:0];
            ndx_c = 1'b0;
            bx_c  = 1'b1;
        end else if (!dir_x && (x_sum <= ZERO)) begin
            nx_c  = '0;
            ndx_c = 1'b1;
            bx_c  = 1'b1;
        end
    end

    always_comb begin
        y_sum = dir_y ? (y_wide + SPY) : (y_wide - SPY);
        ny_c  = y_sum[CORDW-1:0];
        ndy_c = dir_y;
        by_c  = 1'b0;
        if (dir_y && (y_sum >= LY)) begin
            ny_c  = LY[CORDW-1:0];
            ndy_c = 1'b0;
            by_c  = 1'b1;
        end else if (!dir_y && (y_sum <= ZERO)) begin
            ny_c  = '0;
            ndy_c = 1'b1;
            by_c  = 1'b1;
        end
    end

    // Frame pulses only count in IDLE, so pulses during an update are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div      <= '0;
            sprx     <= CORDW'(START_X);
            spry     <= CORDW'(START_Y);
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            busy     <= 1'b0;
            nx_q     <= '0;
            ny_q     <= '0;
            ndx_q    <= 1'b1;
            ndy_q    <= 1'b1;
            bx_q     <= 1'b0;
            by_q     <= 1'b0;
        end else begin
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame && !pause) begin
                        if (div == DIV_LAST) begin
                            div   <= '0;
                            state <= UPD_X;
                            busy  <= 1'b1;
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                end
                UPD_X: begin
                    nx_q  <= nx_c;
                    ndx_q <= ndx_c;
                    bx_q  <= bx_c;
                    state <= UPD_Y;
                end
                UPD_Y: begin
                    ny_q  <= ny_c;
                    ndy_q <= ndy_c;
                    by_q  <= by_c;
                    state <= COMMIT;
                end
                COMMIT: begin
                    sprx     <= nx_q;
                    spry     <= ny_q;
                    dir_x    <= ndx_q;
                    dir_y    <= ndy_q;
                    bounce_x <= bx_q;
                    bounce_y <= by_q;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: four instances with different parameter sets,
// each driven with hand-computed frame sequences and checked cycle by cycle.
module tb_sprite_motion;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst   [4];
    logic               frame [4];
    logic               pause [4];
    logic signed [15:0] sprx  [4];
    logic signed [15:0] spry  [4];
    logic               dir_x [4];
    logic               dir_y [4];
    logic               bx    [4];
    logic               by    [4];
    logic               busy  [4];

    int n_cmp = 0;
    int n_err = 0;

    // 0: defaults, 1: right bounce, 2: bottom bounce, 3: frame divider
    sprite_motion u_def (
        .clk(clk), .rst(rst[0]), .frame(frame[0]), .pause(pause[0]),
        .sprx(sprx[0]), .spry(spry[0]), .dir_x(dir_x[0]), .dir_y(dir_y[0]),
        .bounce_x(bx[0]), .bounce_y(by[0]), .busy(busy[0])
    );
    sprite_motion #(.START_X(606)) u_rb (
        .clk(clk), .rst(rst[1]), .frame(frame[1]), .pause(pause[1]),
        .sprx(sprx[1]), .spry(spry[1]), .dir_x(dir_x[1]), .dir_y(dir_y[1]),
        .bounce_x(bx[1]), .bounce_y(by[1]), .busy(busy[1])
    );
    sprite_motion #(.START_Y(459), .SPEED_Y(2)) u_bb (
        .clk(clk), .rst(rst[2]), .frame(frame[2]), .pause(pause[2]),
        .sprx(sprx[2]), .spry(spry[2]), .dir_x(dir_x[2]), .dir_y(dir_y[2]),
        .bounce_x(bx[2]), .bounce_y(by[2]), .busy(busy[2])
    );
    sprite_motion #(.FRAME_DIV(3)) u_div (
        .clk(clk), .rst(rst[3]), .frame(frame[3]), .pause(pause[3]),
        .sprx(sprx[3]), .spry(spry[3]), .dir_x(dir_x[3]), .dir_y(dir_y[3]),
        .bounce_x(bx[3]), .bounce_y(by[3]), .busy(busy[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int i, input int ex, input int ey);
        check($sformatf("rst_sprx[%0d]", i), sprx[i], ex);
        check($sformatf("rst_spry[%0d]", i), spry[i], ey);
        check($sformatf("rst_dirx[%0d]", i), dir_x[i], 1);
        check($sformatf("rst_diry[%0d]", i), dir_y[i], 1);
        check($sformatf("rst_bx[%0d]", i), bx[i], 0);
        check($sformatf("rst_by[%0d]", i), by[i], 0);
        check($sformatf("rst_busy[%0d]", i), busy[i], 0);
    endtask

    // One accepted frame: three busy cycles with old position, then the commit.
    task automatic do_frame(input int i, input int ox, input int oy, input int ex, input int ey,
                            input int edx, input int edy, input int ebx, input int eby);
        @(negedge clk) frame[i] = 1'b1;
        @(negedge clk) frame[i] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("upd_busy[%0d].%0d", i, k), busy[i], 1);
            check($sformatf("upd_sprx[%0d].%0d", i, k), sprx[i], ox);
            check($sformatf("upd_spry[%0d].%0d", i, k), spry[i], oy);
            check($sformatf("upd_bx[%0d].%0d", i, k), bx[i], 0);
            check($sformatf("upd_by[%0d].%0d", i, k), by[i], 0);
            @(negedge clk);
        end
        check($sformatf("cmt_busy[%0d]", i), busy[i], 0);
        check($sformatf("cmt_sprx[%0d]", i), sprx[i], ex);
        check($sformatf("cmt_spry[%0d]", i), spry[i], ey);
        check($sformatf("cmt_dirx[%0d]", i), dir_x[i], edx);
        check($sformatf("cmt_diry[%0d]", i), dir_y[i], edy);
        check($sformatf("cmt_bx[%0d]", i), bx[i], ebx);
        check($sformatf("cmt_by[%0d]", i), by[i], eby);
        @(negedge clk);
        check($sformatf("post_bx[%0d]", i), bx[i], 0);
        check($sformatf("post_by[%0d]", i), by[i], 0);
    endtask

    // A frame pulse that must not start an update.
    task automatic quiet_frame(input int i, input string tag);
        @(negedge clk) frame[i] = 1'b1;
        @(negedge clk) frame[i] = 1'b0;
        check({tag, "_busy"}, busy[i], 0);
        repeat (3) @(negedge clk);
        check({tag, "_sprx"}, sprx[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i]   = 1'b1;
            frame[i] = 1'b0;
            pause[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;

        check_reset(0, 0, 0);
        check_reset(1, 606, 0);
        check_reset(2, 0, 459);
        check_reset(3, 0, 0);

        // Basic step
        do_frame(0, 0, 0, 2, 1, 1, 1, 0, 0);

        // Right bounce onto LX=608, then back
        do_frame(1, 606, 0, 608, 1, 0, 1, 1, 0);
        do_frame(1, 608, 1, 606, 2, 0, 1, 0, 0);

        // Bottom bounce: 459+2 clamps to LY=460, then back to 458
        do_frame(2, 0, 459, 2, 460, 1, 0, 0, 1);
        do_frame(2, 2, 460, 4, 458, 1, 0, 0, 0);

        // Divider of 3
        quiet_frame(3, "div1");
        quiet_frame(3, "div2");
        do_frame(3, 0, 0, 2, 1, 1, 1, 0, 0);
        pause[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk) frame[3] = 1'b1;
            @(negedge clk) frame[3] = 1'b0;
            check($sformatf("pause_busy.%0d", k), busy[3], 0);
            check($sformatf("pause_sprx.%0d", k), sprx[3], 2);
        end
        @(negedge clk) pause[3] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk) frame[3] = 1'b1;
            @(negedge clk) frame[3] = 1'b0;
            check($sformatf("resume_busy.%0d", k), busy[3], 0);
        end
        do_frame(3, 2, 1, 4, 2, 1, 1, 0, 0);

        // Dropped pulse: frame held across E0 and E1, only one step applied
        @(negedge clk) rst[0] = 1'b1;
        @(negedge clk) rst[0] = 1'b0;
        check_reset(0, 0, 0);
        @(negedge clk) frame[0] = 1'b1;
        @(negedge clk);
        check("drop_busy_e0", busy[0], 1);
        @(negedge clk) frame[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("drop_sprx", sprx[0], 2);
        check("drop_spry", spry[0], 1);
        check("drop_busy_e3", busy[0], 0);
        repeat (5) @(negedge clk);
        check("drop_sprx_late", sprx[0], 2);
        check("drop_busy_late", busy[0], 0);

        // Reset during UPD_Y aborts the update
        @(negedge clk) frame[0] = 1'b1;
        @(negedge clk) frame[0] = 1'b0;
        @(negedge clk) rst[0] = 1'b1;
        @(negedge clk) rst[0] = 1'b0;
        check("abort_sprx", sprx[0], 0);
        check("abort_spry", spry[0], 0);
        check("abort_dirx", dir_x[0], 1);
        check("abort_busy", busy[0], 0);
        check("abort_bx", bx[0], 0);
        @(negedge clk);
        check("abort_bx_late", bx[0], 0);
        check("abort_sprx_late", sprx[0], 0);
        do_frame(0, 0, 0, 2, 1, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
